// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional signed operation is compiled in with `define MDU_SIGNED_EN.
module iter_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             divz
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [3:0]         flags_q, flags_d;
    logic               divz_q, divz_d;

    logic [WIDTH-1:0]   mag_a, mag_b;

`ifdef MDU_SIGNED_EN
    logic sa, sb, neg_q, neg_d, rneg_q, rneg_d;
    assign sa    = sgn & a[WIDTH-1];
    assign sb    = sgn & b[WIDTH-1];
    assign mag_a = sa ? (~a + 1'b1) : a;
    assign mag_b = sb ? (~b + 1'b1) : b;
`else
    logic sgn_unused;
    assign sgn_unused = sgn;
    assign mag_a      = a;
    assign mag_b      = b;
`endif

    // One iteration. acc upper half is the partial product / remainder,
    // lower half shifts out multiplier bits or shifts in quotient bits.
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] step;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opnd_q};
        div_sub = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
        if (op_q[1]) step = {div_sub, acc_q[WIDTH-2:0], div_ge};
        else         step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fin_lo, fin_hi;
    logic               div_zero, n_f, z_f;

    assign div_zero = (opnd_q == '0);

    always_comb begin
        prod = step;
        quo  = step[WIDTH-1:0];
        rem  = step[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
        // Magnitudes ran through the datapath; signs are restored on the final step.
        if (neg_q)               prod = ~step + 1'b1;
        if (neg_q && !div_zero)  quo  = ~step[WIDTH-1:0] + 1'b1;
        if (rneg_q)              rem  = ~step[2*WIDTH-1:WIDTH] + 1'b1;
`endif
        fin_hi = '0;
        case (op_q)
            2'b00:   fin_lo = prod[WIDTH-1:0];
            2'b01: begin
                fin_lo = prod[WIDTH-1:0];
                fin_hi = prod[2*WIDTH-1:WIDTH];
            end
            2'b10:   fin_lo = quo;
            default: fin_lo = rem;
        endcase
        n_f = (op_q == 2'b01) ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
        z_f = (op_q == 2'b01) ? ~|{fin_hi, fin_lo} : ~|fin_lo;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        divz_d  = divz_q;
`ifdef MDU_SIGNED_EN
        neg_d   = neg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
`ifdef MDU_SIGNED_EN
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
`endif
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                    lo_d    = fin_lo;
                    hi_d    = fin_hi;
                    flags_d = {n_f, z_f, 2'b00};
                    divz_d  = op_q[1] & div_zero;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            divz_q  <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            divz_q  <= divz_d;
`ifdef MDU_SIGNED_EN
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign flags     = flags_q;
    assign divz      = divz_q;
endmodule

// File: tb/tb_iter_mdu.sv
// Table-driven bench for iter_mdu (WIDTH=32) with a scoreboard queue of expected results.
module tb_iter_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start, sgn, busy, done, divz;
    logic [1:0]   op;
    logic [W-1:0] a, b, result_lo, result_hi;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    iter_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .flags(flags), .divz(divz)
    );

    typedef struct {
        logic [1:0]   op;
        logic         sgn;
        logic [W-1:0] a, b, lo, hi;
        logic [3:0]   fl;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo, hi;
        logic [3:0]   fl;
        logic         dz;
        int           cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] o, input logic s, input logic [W-1:0] x, y,
                       input logic [W-1:0] lo, hi, input logic [3:0] fl, input logic dz);
        vec_t v;
        v.op = o; v.sgn = s; v.a = x; v.b = y; v.lo = lo; v.hi = hi; v.fl = fl; v.dz = dz;
        vecs.push_back(v);
    endtask

    // Reference for unsigned operation, built from plain wide arithmetic.
    function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, y);
        vec_t v;
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        v.op = o; v.sgn = 1'b0; v.a = x; v.b = y; v.hi = '0; v.dz = 1'b0;
        case (o)
            2'b00: v.lo = p[W-1:0];
            2'b01: begin v.lo = p[W-1:0]; v.hi = p[2*W-1:W]; end
            2'b10: begin v.lo = (y == 0) ? '1 : x / y; v.dz = (y == 0); end
            default: begin v.lo = (y == 0) ? x : x % y; v.dz = (y == 0); end
        endcase
        v.fl = {(o == 2'b01) ? v.hi[W-1] : v.lo[W-1],
                (o == 2'b01) ? ({v.hi, v.lo} == '0) : (v.lo == '0), 2'b00};
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.lo = v.lo; e.hi = v.hi; e.fl = v.fl; e.dz = v.dz; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        op = v.op; sgn = v.sgn; a = v.a; b = v.b; start = 1'b1;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", nm);
        end
    endtask

    task automatic check_result(input string nm, input bit seen);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb: got empty scoreboard expected one entry", nm);
            return;
        end
        e = sb.pop_front();
        if (!seen) return;
        chk({nm, "_lat"},   64'(cyc - e.cyc), 64'(W + 1));
        chk({nm, "_lo"},    result_lo, e.lo);
        chk({nm, "_hi"},    result_hi, e.hi);
        chk({nm, "_flags"}, flags,     e.fl);
        chk({nm, "_divz"},  divz,      e.dz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        vec_t v;
        logic [W-1:0] prev_lo;

        start = 1'b0; op = '0; sgn = 1'b0; a = '0; b = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_lo",    result_lo, 0);
        chk("rst_hi",    result_hi, 0);
        chk("rst_flags", flags, 0);
        chk("rst_divz",  divz, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        add(2'b00, 0, 32'd6,        32'd7,        32'd42,       32'h0,        4'b0000, 0);
        add(2'b01, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 0);
        add(2'b10, 0, 32'd100,      32'd7,        32'd14,       32'h0,        4'b0000, 0);
        add(2'b11, 0, 32'd100,      32'd7,        32'd2,        32'h0,        4'b0000, 0);
        add(2'b10, 0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h0,        4'b1000, 1);
        add(2'b11, 0, 32'd5,        32'd0,        32'd5,        32'h0,        4'b0000, 1);
        add(2'b00, 0, 32'd0,        32'd123,      32'd0,        32'h0,        4'b0100, 0);
        add(2'b01, 0, 32'h80000000, 32'd2,        32'h0,        32'h1,        4'b0000, 0);
        add(2'b00, 0, 32'h00010000, 32'h00010000, 32'h0,        32'h0,        4'b0100, 0);
        add(2'b10, 0, 32'd7,        32'd100,      32'd0,        32'h0,        4'b0100, 0);
        add(2'b11, 0, 32'd7,        32'd100,      32'd7,        32'h0,        4'b0000, 0);
        add(2'b10, 0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0,        4'b1000, 0);
        add(2'b10, 1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'h0,        4'b1000, 1);
        add(2'b11, 1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h0,        4'b1000, 1);
        add(2'b00, 1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'h0,        4'b1000, 0);
`ifdef MDU_SIGNED_EN
        add(2'b10, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'h0,        4'b1000, 0);
        add(2'b11, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'h0,        4'b1000, 0);
        add(2'b01, 1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF, 4'b1000, 0);
        add(2'b10, 1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0,        4'b1000, 0);
`else
        add(2'b10, 1, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'h0,        4'b0000, 0);
        add(2'b11, 1, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h0,        4'b0000, 0);
        add(2'b01, 1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h1,        4'b0000, 0);
        add(2'b10, 1, 32'd7,        32'hFFFFFFFE, 32'd0,        32'h0,        4'b0100, 0);
`endif
        for (int i = 0; i < 8; i++)
            vecs.push_back(model(2'(i), $urandom, (i == 7) ? 32'($urandom_range(1, 300)) : $urandom));

        foreach (vecs[i]) begin
            issue(vecs[i]);
            wait_done($sformatf("v%0d", i), seen);
            check_result($sformatf("v%0d", i), seen);
            prev_lo = result_lo;
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), done, 0);
            chk($sformatf("v%0d_hold", i), result_lo, prev_lo);
        end

        // start held high throughout a running operation with changing operands
        @(negedge clk);
        op = 2'b00; sgn = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
        v = model(2'b00, 32'd6, 32'd7);
        push_exp(v);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                op = 2'($urandom); a = $urandom; b = $urandom;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL spam_timeout: got no done expected done within 100 cycles");
        end
        check_result("spam", seen);

        // next accept in the cycle right after done
        @(negedge clk);
        chk("spam_pulse", done, 0);
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        push_exp(model(2'b10, 32'd100, 32'd7));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_done("b2b", seen);
        check_result("b2b", seen);

        // reset 10 cycles into an operation
        @(negedge clk);
        op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_done",  done, 0);
        chk("mid_rst_lo",    result_lo, 0);
        chk("mid_rst_hi",    result_hi, 0);
        chk("mid_rst_flags", flags, 0);
        chk("mid_rst_divz",  divz, 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("rst_no_done", 64'(n), 0);
        chk("rst_idle", busy, 0);

        // accept on the first edge after reset release
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        op = 2'b11; sgn = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        push_exp(model(2'b11, 32'd100, 32'd7));
        @(negedge clk);
        start = 1'b0;
        chk("rel_busy", busy, 1);
        wait_done("rel", seen);
        check_result("rel", seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
